// File: rtl/acia_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : acia_tx_serializer
//  Purpose  : ACIA transmit path. Holding register, baud divider and
//             start/data/parity/stop frame serialiser with tdre/ovr status.
//  Revision : 1.0  initial release
// ============================================================================
module acia_tx_serializer #(
    parameter int BAUD_DIV = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    input  logic       cfg_bits7,
    input  logic [1:0] cfg_parity,
    input  logic       cfg_stop2,
    input  logic       clr_ovr,
    output logic       txd,
    output logic       tdre,
    output logic       busy,
    output logic       ovr
);

    localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic        r_stop_cnt, w_stop_cnt_nxt;
    logic        r_bits7, w_bits7_nxt;
    logic        r_stop2, w_stop2_nxt;
    logic        r_par_en, w_par_en_nxt;
    logic        r_par_bit, w_par_bit_nxt;
    logic        r_txd, w_txd_nxt;
    logic [7:0]  r_hold_data;
    logic        r_hold_valid;
    logic        r_ovr;
    logic        w_bit_tick;
    logic        w_load;
    logic [2:0]  w_bit_last;
    logic        w_data_xor;

    assign w_bit_tick = clk_en && (r_baud_cnt == c_BAUD_LAST) && (r_state != S_IDLE);
    assign w_bit_last = r_bits7 ? 3'd6 : 3'd7;
    assign w_data_xor = cfg_bits7 ? ^r_hold_data[6:0] : ^r_hold_data;

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_bits7_nxt    = r_bits7;
        w_stop2_nxt    = r_stop2;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_txd_nxt      = r_txd;
        w_load         = 1'b0;

        if (r_state == S_IDLE) begin
            w_baud_cnt_nxt = 16'd0;
        end else if (clk_en) begin
            w_baud_cnt_nxt = w_bit_tick ? 16'd0 : r_baud_cnt + 16'd1;
        end

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (r_hold_valid) w_load = 1'b1;
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_txd_nxt     = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == w_bit_last) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (r_par_en) begin
                            w_txd_nxt   = r_par_bit;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_txd_nxt   = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_txd_nxt     = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_txd_nxt      = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    if (r_stop_cnt == r_stop2) begin
                        // A waiting byte starts its frame with no idle gap
                        if (r_hold_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_txd_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Transfer: configuration is frozen here for the whole frame
        if (w_load) begin
            w_state_nxt    = S_START;
            w_txd_nxt      = 1'b0;
            w_shift_nxt    = r_hold_data;
            w_baud_cnt_nxt = 16'd0;
            w_bits7_nxt    = cfg_bits7;
            w_stop2_nxt    = cfg_stop2;
            w_par_en_nxt   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            w_par_bit_nxt  = w_data_xor ^ (cfg_parity == 2'b10);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_bits7    <= 1'b0;
            r_stop2    <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_bits7    <= w_bits7_nxt;
            r_stop2    <= w_stop2_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_data  <= 8'd0;
            r_hold_valid <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            if (wr_strobe && !r_hold_valid) begin
                r_hold_data  <= wr_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            // Overrun write beats a simultaneous clear
            if (wr_strobe && r_hold_valid) r_ovr <= 1'b1;
            else if (clr_ovr)              r_ovr <= 1'b0;
        end
    end

    assign txd  = r_txd;
    assign tdre = ~r_hold_valid;
    assign busy = (r_state != S_IDLE);
    assign ovr  = r_ovr;

endmodule
`default_nettype wire
